// File: rtl/delay_line_pkg.sv
// Shared defaults and read-FSM encoding for the audio delay line.
package delay_line_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 24;
  localparam int unsigned ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_LATCH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Non-blocking update gives the old word on a same-address read and write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/delay_line_ram.sv
// Circular-buffer audio delay line with a two-cycle-latency offset read.
// Ports: clk, rst (async active-low); sample_in/sample_valid write a new sample;
// rd/offset request the sample written offset samples ago; data_out/read_finish
// return it two cycles later; busy flags a read in flight.
module delay_line_ram
  import delay_line_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_finish,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wp_q;
  logic [ADDR_WIDTH:0]   fill_q;
  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  zflag_q, zflag_d;
  logic                  busy_d, finish_d;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_re_c;

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (sample_valid),
    .waddr(wp_q),
    .wdata(sample_in),
    .re   (ram_re_c),
    .raddr(raddr_q),
    .rdata(ram_q)
  );

  // Write pointer and saturating fill counter; writes never stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q   <= '0;
      fill_q <= '0;
    end else if (sample_valid) begin
      wp_q <= wp_q + ADDR_WIDTH'(1);
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Read FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      raddr_q     <= '0;
      zflag_q     <= 1'b0;
      busy        <= 1'b0;
      read_finish <= 1'b0;
      data_out    <= '0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      zflag_q     <= zflag_d;
      busy        <= busy_d;
      read_finish <= finish_d;
      data_out    <= dout_d;
    end
  end

  // Next-state logic; the address snapshot uses wp/fill before any same-cycle write.
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    zflag_d  = zflag_q;
    busy_d   = busy;
    finish_d = 1'b0;
    dout_d   = data_out;
    ram_re_c = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (rd) begin
          raddr_d = wp_q - offset - ADDR_WIDTH'(1);
          zflag_d = ({1'b0, offset} >= fill_q);
          busy_d  = 1'b1;
          state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        ram_re_c = 1'b1;
        state_d  = RD_LATCH;
      end
      RD_LATCH: begin
        dout_d   = zflag_q ? '0 : ram_q;
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = RD_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = RD_IDLE;
      end
    endcase
  end

endmodule

// File: doc/delay_line_ram.md
DELAY_LINE_RAM -- requirements
Module: delay_line_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 24, meaning sample width in bits (two's complement).
REQ-002 Parameter ADDR_WIDTH, default 12, meaning log2 of buffer depth (DEPTH = 2^ADDR_WIDTH words).
REQ-003 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, meaning asynchronous active-low reset; one clock domain; reset is asynchronous and active-low.
REQ-005 Port sample_in, input, DATA_WIDTH, meaning new audio sample from the codec side.
REQ-006 Port sample_valid, input, 1, meaning single-cycle strobe: write sample_in into the delay line.
REQ-007 Port rd, input, 1, meaning single-cycle read request from the effect stage.
REQ-008 Port offset, input, ADDR_WIDTH, meaning delay in samples; 0 = most recently written sample.
REQ-009 Port data_out, output, DATA_WIDTH, meaning read result.
REQ-010 Port read_finish, output, 1, meaning one-cycle pulse: data_out valid for the accepted read.
REQ-011 Port busy, output, 1, meaning high while a read is in flight; rd ignored while high.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH words with write pointer wp (ADDR_WIDTH bits) and fill counter fill (ADDR_WIDTH+1 bits).
REQ-013 On sample_valid, mem[wp] <= sample_in, wp <= wp+1 (modulo DEPTH wrap), fill <= min(fill+1, DEPTH).
REQ-014 Writes SHALL proceed independently of read state; no sample_valid is ever dropped or stalled.
REQ-015 Read FSM states: IDLE, FETCH, LATCH; reset state IDLE.
REQ-016 IDLE: on rd, snapshot raddr = (wp - 1 - offset) mod DEPTH and zero_flag = (offset >= fill), go FETCH, busy=1.
REQ-017 FETCH: RAM read of raddr (one-cycle synchronous latency), go LATCH.
REQ-018 LATCH: data_out <= zero_flag ? 0 : mem word, read_finish=1 for this cycle only, busy=0, go IDLE.
REQ-019 Latency: rd sampled in cycle n -> read_finish high and data_out valid in cycle n+2 (on the register outputs after edge n+2); a new rd is accepted from cycle n+2 onward.
REQ-020 data_out SHALL hold its value until the next LATCH; read_finish SHALL never be high for two consecutive cycles.
REQ-021 rd while busy=1 SHALL be ignored (no queueing).
REQ-022 Address snapshot uses wp before any same-cycle write; sample_valid coincident with rd does not shift the addressed sample.
REQ-023 Read-during-write to the same word (offset = DEPTH-1 with full buffer) SHALL return the old (pre-write) data.
REQ-024 Offset arithmetic is unsigned modulo DEPTH; no out-of-range condition beyond REQ-016 zero_flag.

Reset
REQ-025 rst low SHALL asynchronously force wp=0, fill=0, FSM=IDLE, busy=0, read_finish=0, data_out=0.
REQ-026 Reset mid-read SHALL abort the read; no read_finish pulse follows reset release.
REQ-027 Memory contents are not cleared; fill=0 guarantees zero reads until rewritten.

Structure
REQ-028 DATA_WIDTH/ADDR_WIDTH defaults and FSM state encodings SHALL live in shared package delay_line_pkg.
REQ-029 Storage SHALL be one sub-module sdp_ram (simple dual-port, one write port, one registered read port, read-before-write) to infer block RAM.
REQ-030 FSM, pointers and fill counter SHALL live in delay_line_ram top.

Verification
REQ-031 Reset, write 1,2,3 (three sample_valid), rd offset=0 -> read_finish two cycles later, data_out=3; offset=2 -> data_out=1.
REQ-032 After reset write 5 samples, rd offset=5 -> data_out=0 (zero_flag); rd offset=4 -> first sample.
REQ-033 Write 4100 samples valued 0..4099, rd offset=0 -> 4099, offset=4095 -> 4 (wrap-around, fill saturated at 4096).
REQ-034 rd and sample_valid (value 0x7FFFFF) in the same cycle with offset=0 -> data_out = previous sample, not 0x7FFFFF.
REQ-035 rd pulsed again one cycle after accepted rd -> exactly one read_finish; second rd ignored.
REQ-036 Assert rst low during FETCH -> busy=0, data_out=0 immediately; no read_finish after release.
